arb_client: RTL
===============

ARB_CLIENT -- requirements
Module: arb_client

Interface
REQ-001 Parameter LEN_W, default 8, width of transfer length in beats.
REQ-002 Parameter TIMEOUT, default 16, max cycles in REQ waiting for gnt before abandoning (range 2..255).
REQ-003 clock  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset; forces reset values immediately, released synchronously to clock.
REQ-005 cmd_valid  input  1  command offered by local logic.
REQ-006 cmd_len  input  LEN_W  number of beats requested; sampled when cmd_valid and cmd_ready are both 1.
REQ-007 cmd_ready  output  1  block can accept a command (1 only in IDLE).
REQ-008 req  output  1  active-high request to the 4-way arbiter's req_N input.
REQ-009 gnt  input  1  active-high grant from the arbiter's gnt_N output; registered at the arbiter, lags req by 2 cycles, may stay high up to 2 cycles after req drops.
REQ-010 xfer_en  output  1  beat strobe; one beat per cycle high.
REQ-011 done  output  1  one-cycle pulse: command completed normally.
REQ-012 timeout  output  1  one-cycle pulse: grant not obtained within TIMEOUT cycles.
REQ-013 err  output  1  one-cycle pulse: grant lost mid-transfer.

Function
REQ-014 State machine SHALL have states IDLE, REQ, XFER, RELEASE; encoding free, unreachable encodings SHALL go to IDLE next cycle.
REQ-015 IDLE: cmd_ready=1, req=0; on cmd_valid&cmd_ready with cmd_len!=0, latch cmd_len into remaining-beat counter, clear wait counter, go REQ.
REQ-016 IDLE with cmd_valid and cmd_len==0: accept command, stay IDLE, pulse done next cycle, never assert req.
REQ-017 req SHALL be 1 exactly in REQ and XFER states, derived from registered state only (glitch-free).
REQ-018 REQ: wait counter increments each cycle gnt=0; gnt=1 -> go XFER next cycle (no beat in the REQ cycle).
REQ-019 REQ: if gnt=0 in the cycle the wait counter equals TIMEOUT-1, go RELEASE and pulse timeout in the following cycle; gnt=1 in that same cycle takes priority (go XFER, no timeout).
REQ-020 XFER: xfer_en = gnt (combinational from registered state and gnt input); each cycle with gnt=1 decrements remaining count by 1.
REQ-021 XFER: gnt=1 with remaining==1 -> last beat; go RELEASE, pulse done next cycle; total xfer_en high cycles equal latched cmd_len exactly.
REQ-022 XFER: gnt=0 -> no beat, go RELEASE, pulse err next cycle; remaining count discarded.
REQ-023 RELEASE: req=0, cmd_ready=0; stay until gnt=0 observed, then IDLE next cycle; guarantees arbiter returned to its idle state before re-request.
REQ-024 done, timeout, err SHALL be registered, mutually exclusive, each high for exactly one cycle per event.
REQ-025 cmd_len and cmd_valid changes outside the acceptance cycle SHALL have no effect.
REQ-026 Counters SHALL not wrap: remaining count width LEN_W, cmd_len max 2^LEN_W-1 beats; wait counter saturates at TIMEOUT-1.

Reset
REQ-027 On reset: state=IDLE, req=0, cmd_ready=1, done=0, timeout=0, err=0, counters=0; xfer_en=0.
REQ-028 Reset asserted mid-XFER or mid-REQ SHALL drop req in the same cycle (asynchronously), with no done/err/timeout pulse.
REQ-029 First command SHALL be accepted on the first rising edge after reset deassertion with cmd_valid=1.

Verification
REQ-030 cmd_len=3, arbiter model grants 2 cycles after req and holds while req=1 -> req high 6 cycles, xfer_en high 3 consecutive cycles, done pulse once, IDLE after gnt falls.
REQ-031 cmd_len=0 -> cmd accepted, done pulse next cycle, req never asserted, cmd_ready stays 1.
REQ-032 TIMEOUT=16, gnt held 0 -> req high 16 cycles, timeout pulse once, return to IDLE, no xfer_en.
REQ-033 cmd_len=5, gnt drops after 2 beats -> xfer_en 2 cycles, err pulse once, no done, RELEASE until gnt=0.
REQ-034 gnt arrives in cycle wait counter = TIMEOUT-1 -> XFER entered, no timeout pulse, full transfer completes with done.
REQ-035 Reset asserted during XFER beat 2 of cmd_len=4 -> req=0 immediately, all outputs at reset values, next command after release completes normally with 4 beats.

Source files
------------

// File: rtl/arb_client_if.sv
// Command and arbiter-handshake bundle for arb_client.
// The master modport is the client; slave is the local logic plus arbiter side.
interface arb_client_if #(
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_ready;
  logic             req;
  logic             gnt;
  logic             xfer_en;
  logic             done;
  logic             timeout;
  logic             err;

  modport master (
    input  cmd_valid, cmd_len, gnt,
    output cmd_ready, req, xfer_en, done, timeout, err
  );

  modport slave (
    output cmd_valid, cmd_len, gnt,
    input  cmd_ready, req, xfer_en, done, timeout, err
  );
endinterface

// File: rtl/arb_client.sv
// Arbiter client: requests a grant, streams cmd_len beats while the grant is held,
// and reports completion, grant timeout or a grant lost mid-transfer.
module arb_client #(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 16
) (
  input logic          clock,
  input logic          reset,
  arb_client_if.master bus
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_XFER    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]       state, state_nxt;
  logic [LEN_W-1:0] remaining, remaining_nxt;
  logic [7:0]       wait_cnt, wait_nxt;
  logic             done_q, timeout_q, err_q;
  logic             done_nxt, timeout_nxt, err_nxt;
  logic             accept;
  logic             last_beat;
  logic             wait_expired;

  assign accept       = (state == S_IDLE) && bus.cmd_valid;
  assign last_beat    = (remaining <= LEN_W'(1));
  assign wait_expired = (wait_cnt >= WAIT_LAST);

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    wait_nxt      = wait_cnt;
    done_nxt      = 1'b0;
    timeout_nxt   = 1'b0;
    err_nxt       = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (bus.cmd_len == '0) begin
            done_nxt = 1'b1;
          end else begin
            remaining_nxt = bus.cmd_len;
            wait_nxt      = '0;
            state_nxt     = S_REQ;
          end
        end
      end
      S_REQ: begin
        // A grant in the final wait cycle still wins over the timeout.
        if (bus.gnt) begin
          state_nxt = S_XFER;
        end else if (wait_expired) begin
          state_nxt   = S_RELEASE;
          timeout_nxt = 1'b1;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      S_XFER: begin
        if (bus.gnt) begin
          remaining_nxt = remaining - LEN_W'(1);
          if (last_beat) begin
            state_nxt = S_RELEASE;
            done_nxt  = 1'b1;
          end
        end else begin
          remaining_nxt = '0;
          state_nxt     = S_RELEASE;
          err_nxt       = 1'b1;
        end
      end
      S_RELEASE: begin
        // Hold off re-requesting until the arbiter's registered grant has drained.
        if (!bus.gnt) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      wait_cnt  <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      wait_cnt  <= wait_nxt;
      done_q    <= done_nxt;
      timeout_q <= timeout_nxt;
      err_q     <= err_nxt;
    end
  end

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.req       = (state == S_REQ) || (state == S_XFER);
  assign bus.xfer_en   = (state == S_XFER) && bus.gnt;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;
  assign bus.err       = err_q;
endmodule
